// File: rtl/flex_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : flex_down_counter
// Brief    : Loadable, parameter-width down counter with registered expire
//            pulse, done level and optional auto-reload for periodic expiry.
//            Optional feature macro: FLEX_DOWN_COUNTER_HALF_FLAG_EN adds a
//            registered half_flag output (high in RUN once the count is at or
//            below half of the reload value).
// Revision : 1.0 - initial release
// ============================================================================
module flex_down_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    load,
   input  logic [NUM_CNT_BITS-1:0] load_val,
   input  logic                    count_enable,
   input  logic                    auto_reload,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    busy,
   output logic                    done,
   output logic                    expire
`ifdef FLEX_DOWN_COUNTER_HALF_FLAG_EN
   ,
   output logic                    half_flag
`endif
);

   localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);
   localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [NUM_CNT_BITS-1:0] count_next;
   logic [NUM_CNT_BITS-1:0] reload;
   logic [NUM_CNT_BITS-1:0] reload_next;
   logic                    expire_next;

   // State, count, reload value and expire pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count_out <= CNT_ZERO;
         reload    <= CNT_ZERO;
         expire    <= 1'b0;
      end else begin
         state     <= state_next;
         count_out <= count_next;
         reload    <= reload_next;
         expire    <= expire_next;
      end
   end

   // Next-state logic with clear > load > count_enable priority.
   always_comb begin
      state_next  = state;
      count_next  = count_out;
      reload_next = reload;
      expire_next = 1'b0;

      if (clear) begin
         // Abort: reload register is intentionally kept.
         state_next = IDLE;
         count_next = CNT_ZERO;
      end else if (load) begin
         // A zero load completes immediately and silently (no expire).
         count_next  = load_val;
         reload_next = load_val;
         state_next  = (load_val != CNT_ZERO) ? RUN : DONE;
      end else if ((state == RUN) && count_enable) begin
         if (count_out > CNT_ONE) begin
            count_next = count_out - CNT_ONE;
         end else if (auto_reload) begin
            // auto_reload only matters on this, the expiry strobe.
            count_next  = reload;
            expire_next = 1'b1;
         end else begin
            // Saturate at zero; RUN never holds a zero count.
            count_next  = CNT_ZERO;
            state_next  = DONE;
            expire_next = 1'b1;
         end
      end
   end

   // Status levels decoded from the registered state.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

`ifdef FLEX_DOWN_COUNTER_HALF_FLAG_EN
   logic half_next;

   // Half-way indicator evaluated on the values the counter is about to take.
   always_comb begin
      half_next = (state_next == RUN) && (count_next <= (reload_next >> 1));
   end

   // Register the half-way indicator so it aligns with count_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_flag <= 1'b0;
      end else begin
         half_flag <= half_next;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_flex_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flex_down_counter
// Brief    : Directed bench for flex_down_counter with a behavioural model
//            compared every cycle, plus literal expectations per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flex_down_counter;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       load;
   logic [3:0] load_val;
   logic       count_enable;
   logic       auto_reload;
   logic [3:0] count_out;
   logic       busy;
   logic       done;
   logic       expire;
`ifdef FLEX_DOWN_COUNTER_HALF_FLAG_EN
   logic       half_flag;
`endif

   int errors = 0;
   int checks = 0;

   flex_down_counter #(.NUM_CNT_BITS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .load         (load),
      .load_val     (load_val),
      .count_enable (count_enable),
      .auto_reload  (auto_reload),
      .count_out    (count_out),
      .busy         (busy),
      .done         (done),
      .expire       (expire)
`ifdef FLEX_DOWN_COUNTER_HALF_FLAG_EN
      ,
      .half_flag    (half_flag)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: remaining count, reload value, running/finished flags.
   int m_count;
   int m_reload;
   bit m_run;
   bit m_done;
   bit m_expire;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_count  <= 0;
         m_reload <= 0;
         m_run    <= 0;
         m_done   <= 0;
         m_expire <= 0;
      end else begin
         m_expire <= 0;
         if (clear) begin
            m_count <= 0;
            m_run   <= 0;
            m_done  <= 0;
         end else if (load) begin
            m_count  <= int'(load_val);
            m_reload <= int'(load_val);
            m_run    <= (load_val != 0);
            m_done   <= (load_val == 0);
         end else if (m_run && count_enable) begin
            if (m_count == 1) begin
               m_expire <= 1;
               if (auto_reload) begin
                  m_count <= m_reload;
               end else begin
                  m_count <= 0;
                  m_run   <= 0;
                  m_done  <= 1;
               end
            end else begin
               m_count <= m_count - 1;
            end
         end
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare DUT outputs with the model in the middle of every cycle.
   always @(negedge clk) begin
      check("model count_out", int'(count_out), m_count);
      check("model busy",      int'(busy),      int'(m_run));
      check("model done",      int'(done),      int'(m_done));
      check("model expire",    int'(expire),    int'(m_expire));
`ifdef FLEX_DOWN_COUNTER_HALF_FLAG_EN
      check("model half_flag", int'(half_flag),
            int'(m_run && (m_count <= (m_reload / 2))));
`endif
   end

   // Apply one cycle of inputs at the falling edge; return just after the rise.
   task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                        input logic en, input logic ar);
      @(negedge clk);
      clear        = c;
      load         = l;
      load_val     = lv;
      count_enable = en;
      auto_reload  = ar;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input int cnt, input int b,
                             input int d, input int e);
      check({name, " count_out"}, int'(count_out), cnt);
      check({name, " busy"},      int'(busy),      b);
      check({name, " done"},      int'(done),      d);
      check({name, " expire"},    int'(expire),    e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int basic_cnt [5];
      int gap_cnt [6];
      int gap_exp [6];
      int ar_cnt [12];
      int n_expire;
      int n_done;

      basic_cnt = '{4, 3, 2, 1, 0};
      gap_cnt   = '{2, 2, 1, 1, 0, 0};
      gap_exp   = '{0, 0, 0, 0, 1, 0};
      ar_cnt    = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};

      rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = 4'd0;
      count_enable = 1'b0; auto_reload = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      expect_out("reset", 0, 0, 0, 0);
      #2 rst = 1'b0;

      // Reset mid-count: outputs drop without a clock edge.
      drive(0, 1, 4'd9, 0, 0);
      repeat (3) drive(0, 0, 4'd0, 1, 0);
      expect_out("pre-reset", 6, 1, 0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 expect_out("async reset", 0, 0, 0, 0);
      #1 rst = 1'b0;
      count_enable = 1'b0;

      // Basic countdown from 5.
      drive(0, 1, 4'd5, 0, 0);
      expect_out("load5", 5, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 4'd0, 1, 0);
         expect_out("basic", basic_cnt[i], (i < 4) ? 1 : 0, (i == 4) ? 1 : 0,
                    (i == 4) ? 1 : 0);
      end
      drive(0, 0, 4'd0, 0, 0);
      expect_out("basic hold", 0, 0, 1, 0);

      // Gapped enables, then enables in DONE must not wrap.
      drive(0, 1, 4'd3, 0, 0);
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 4'd0, (i % 2 == 0) ? 1'b1 : 1'b0, 0);
         check("gap count_out", int'(count_out), gap_cnt[i]);
         check("gap expire",    int'(expire),    gap_exp[i]);
      end
      drive(0, 0, 4'd0, 1, 0);
      drive(0, 0, 4'd0, 1, 0);
      expect_out("done enable", 0, 0, 1, 0);

      // Auto-reload with period 4.
      drive(0, 1, 4'd4, 0, 1);
      n_expire = 0;
      n_done   = 0;
      for (int i = 0; i < 12; i++) begin
         drive(0, 0, 4'd0, 1, 1);
         check("autoreload count_out", int'(count_out), ar_cnt[i]);
         n_expire += int'(expire);
         n_done   += int'(done);
      end
      check("autoreload expires", n_expire, 3);
      check("autoreload done",    n_done,   0);

      // Auto-reload with value 1: expire every enabled cycle.
      drive(0, 1, 4'd1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 4'd0, 1, 1);
         expect_out("reload1", 1, 1, 0, 1);
      end
      drive(0, 0, 4'd0, 0, 1);
      expect_out("reload1 idle strobe", 1, 1, 0, 0);

      // Priority and edge values.
      drive(1, 1, 4'd7, 1, 0);
      expect_out("clear over load", 0, 0, 0, 0);
      drive(0, 1, 4'd0, 0, 0);
      expect_out("load zero", 0, 0, 1, 0);
      drive(0, 1, 4'd3, 0, 0);
      drive(0, 0, 4'd0, 1, 0);
      expect_out("count at 2", 2, 1, 0, 0);
      drive(0, 1, 4'd15, 1, 0);
      expect_out("reload mid run", 15, 1, 0, 0);
      drive(1, 0, 4'd0, 1, 0);
      expect_out("clear from run", 0, 0, 0, 0);

      // Maximum load: 15 enabled cycles to expiry.
      drive(0, 1, 4'd15, 0, 0);
      repeat (14) drive(0, 0, 4'd0, 1, 0);
      expect_out("max before", 1, 1, 0, 0);
      drive(0, 0, 4'd0, 1, 0);
      expect_out("max expire", 0, 0, 1, 1);

`ifdef FLEX_DOWN_COUNTER_HALF_FLAG_EN
      // Half flag from a load of 8.
      drive(0, 1, 4'd8, 0, 0);
      check("half at 8", int'(half_flag), 0);
      for (int i = 7; i >= 0; i--) begin
         drive(0, 0, 4'd0, 1, 0);
         check("half step", int'(half_flag), (i <= 4 && i >= 1) ? 1 : 0);
      end
`endif

      drive(0, 0, 4'd0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
